bw_seq_mult: RTL
================

BW_SEQ_MULT -- requirements
Module: bw_seq_mult

Interface
REQ-001 SHALL provide parameter p_width, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL provide port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset_i  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port valid_i  input  1  operand request valid.
REQ-005 SHALL provide port ready_o  output  1  block can accept operands.
REQ-006 SHALL provide port a_i  input  p_width  multiplicand.
REQ-007 SHALL provide port b_i  input  p_width  multiplier.
REQ-008 SHALL provide port signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL provide port valid_o  output  1  product_o holds a completed result.
REQ-010 SHALL provide port ready_i  input  1  consumer accepts product.
REQ-011 SHALL provide port product_o  output  2*p_width  result, signed or unsigned per captured signed_i.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-013 SHALL accept on the edge where valid_i && ready_o, capturing a_i, b_i, signed_i into internal registers and moving IDLE -> BUSY; later input changes SHALL NOT affect the result.
REQ-014 SHALL process one partial-product row (one bit of b) per BUSY cycle, LSB first, using an iteration counter 0..p_width-1.
REQ-015 SHALL, in signed mode, apply Baugh-Wooley rules: rows 0..p_width-2 invert the a MSB term, row p_width-1 inverts all terms except the MSB term, and constant 1 is added at bit positions p_width and 2*p_width-1.
REQ-016 SHALL, in unsigned mode, sum plain AND partial products with no inversion or correction constants.
REQ-017 SHALL keep the accumulator 2*p_width bits wide and discard carry-out above bit 2*p_width-1.
REQ-018 SHALL move BUSY -> DONE on the edge completing iteration p_width-1; for acceptance at edge T, valid_o SHALL first be high after edge T+p_width.
REQ-019 SHALL hold product_o and valid_o stable in DONE until ready_i = 1; DONE -> IDLE on the edge where valid_o && ready_i.
REQ-020 SHALL NOT accept new operands in the cycle the result is consumed; ready_o rises the cycle after.
REQ-021 SHALL ignore valid_i while in BUSY or DONE.
REQ-022 SHALL produce product_o bit-exact to a_i*b_i over all 2^(2*p_width) operand pairs in each mode.

Reset
REQ-023 SHALL, on reset_i = 1 at a clock edge, enter IDLE, clear the counter, accumulator and operand registers, and drive ready_o = 0, valid_o = 0, product_o = 0 during the reset cycle.
REQ-024 SHALL abort any BUSY or DONE operation on reset without emitting its result; ready_o = 1 on the first edge with reset_i = 0.

Configuration
REQ-025 SHALL support macro BW_SEQ_MULT_EARLY_EXIT_EN.
REQ-026 SHALL, with BW_SEQ_MULT_EARLY_EXIT_EN defined, go from acceptance directly to DONE with product_o = 0 when a_i == 0 or b_i == 0, so valid_o is high after edge T+1.
REQ-027 SHALL, without BW_SEQ_MULT_EARLY_EXIT_EN, take the full p_width iterations for every operand pair, including zero operands.

Verification (p_width = 8)
REQ-028 Signed -128 x -128 with ready_i = 1 -> product_o = 16384 (0x4000), valid_o high exactly 8 edges after acceptance, one cycle.
REQ-029 Signed -1 x 1 -> 0xFFFF; unsigned 255 x 255 -> 0xFE01; signed 127 x -128 -> 0xC080 (-16256).
REQ-030 Signed 3 x -5 with ready_i = 0 for 5 cycles after valid_o -> product_o = 0xFFF1 held, ready_o = 0 throughout; valid_i pulses during the stall are ignored.
REQ-031 Reset asserted 4 cycles into BUSY -> valid_o never rises for that op; next op 7 x 6 -> 42.
REQ-032 0 x 93 signed -> 0; with BW_SEQ_MULT_EARLY_EXIT_EN valid_o 1 edge after acceptance, without it 8 edges.
REQ-033 Exhaustive sweep of all 65536 pairs in both modes, with random ready_i back-pressure -> every result equals the reference product.

Source files
------------

// File: rtl/bw_seq_mult.sv
// rtl/bw_seq_mult.sv - sequential Baugh-Wooley multiplier, one partial-product row per cycle
// Optional zero-operand early exit: define BW_SEQ_MULT_EARLY_EXIT_EN.
module bw_seq_mult #(
  parameter int p_width = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [p_width-1:0]   a_i,
  input  logic [p_width-1:0]   b_i,
  input  logic                 signed_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*p_width-1:0] product_o
);

  localparam int cw  = (p_width > 1) ? $clog2(p_width) : 1;
  localparam int pw2 = 2 * p_width;
  localparam logic [pw2-1:0] c_one  = pw2'(1);
  localparam logic [pw2-1:0] c_corr = (c_one << p_width) | (c_one << (pw2 - 1));

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [p_width-1:0] a_q, b_q;
  logic               s_q;
  logic [cw-1:0]      cnt;
  logic [pw2-1:0]     acc;
  logic [p_width-1:0] row;
  logic [pw2-1:0]     addend;
  logic               last;
`ifdef BW_SEQ_MULT_EARLY_EXIT_EN
  logic               zero_q;
`endif

  assign last = (cnt == cw'(p_width - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = !reset_i;
        if (valid_i) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
`ifdef BW_SEQ_MULT_EARLY_EXIT_EN
        if (last || zero_q) state_nxt = DONE;
`else
        if (last) state_nxt = DONE;
`endif
      end
      DONE: begin
        valid_o = !reset_i;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed rows: NAND the a-MSB term on rows 0..W-2; on the last row NAND every term but the MSB.
  always_comb begin
    row = '0;
    for (int j = 0; j < p_width; j++) begin
      row[j] = a_q[j] & b_q[cnt];
      if (s_q && ((j == p_width - 1) != last)) row[j] = ~row[j];
    end
    addend = {{p_width{1'b0}}, row} << cnt;
    if (s_q && (cnt == '0)) addend = addend + c_corr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
`ifdef BW_SEQ_MULT_EARLY_EXIT_EN
      zero_q <= 1'b0;
`endif
    end else if (accept) begin
      a_q    <= a_i;
      b_q    <= b_i;
      s_q    <= signed_i;
      cnt    <= '0;
      acc    <= '0;
`ifdef BW_SEQ_MULT_EARLY_EXIT_EN
      zero_q <= (a_i == '0) || (b_i == '0);
`endif
    end else if (state == BUSY) begin
      cnt <= cnt + cw'(1);
`ifdef BW_SEQ_MULT_EARLY_EXIT_EN
      if (!zero_q) acc <= acc + addend;
`else
      acc <= acc + addend;
`endif
    end
  end

  assign product_o = reset_i ? '0 : acc;

endmodule
